// File: rtl/pfb_circ_shift_pkg.sv
// Shared constants, types and helpers for the PFB circular-shift reorder block.
//   ADDR_WIDTH / DATA_WIDTH : default frame-address and sample widths
//   rd_pipe_t               : sideband carried alongside each RAM read
//   calc_rd_addr            : rotated read address within a frame
package pfb_circ_shift_pkg;

    localparam int ADDR_WIDTH      = 11;
    localparam int DATA_WIDTH      = 32;
    localparam int FIFO_ADDR_WIDTH = 3;

    typedef struct packed {
        logic                  valid;
        logic                  tlast;
        logic [ADDR_WIDTH-1:0] phase;
    } rd_pipe_t;

    // Odd frames are read starting at M/2 and wrap modulo M.
    function automatic logic [ADDR_WIDTH-1:0] calc_rd_addr(
        input logic [ADDR_WIDTH-1:0] cnt,
        input logic                  parity,
        input logic [ADDR_WIDTH-1:0] half,
        input logic [ADDR_WIDTH-1:0] mask
    );
        logic [ADDR_WIDTH-1:0] ofs;
        ofs = parity ? half : '0;
        return (cnt + ofs) & mask;
    endfunction

endpackage

// File: rtl/pfb_circ_shift_2048mmax_ram.sv
// Simple dual-port block RAM, read-first, two-cycle read latency
// (registered address, registered data).
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_addr          : read address, sampled every cycle
//   rd_data          : data for the address presented two cycles earlier
module pfb_circ_shift_2048mmax_ram
    import pfb_circ_shift_pkg::*;
#(
    parameter int RAM_AW = 12,
    parameter int RAM_DW = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [RAM_AW-1:0] wr_addr,
    input  logic [RAM_DW-1:0] wr_data,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic [RAM_DW-1:0] rd_data
);

    logic [RAM_DW-1:0] mem [2**RAM_AW];
    logic [RAM_AW-1:0] rd_addr_q;
    logic [RAM_DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_addr_q <= rd_addr;
        // Non-blocking read returns the old word on a same-cycle write,
        // so a bank can be refilled while its last words are in flight.
        rd_data_q <= mem[rd_addr_q];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pfb_circ_shift_2048mmax.sv
// Ping-pong frame buffer between the M-path PFB and the IFFT. Each frame of
// M samples is written by PFB phase, then read back in natural bin order,
// rotated by M/2 on odd frames to cancel the M/2 channelizer phase alias.
//   clk, sync_reset_n  : clock, synchronous active-low reset
//   num_phases         : M (power of two, 8..2048), static outside reset
//   s_axis_*           : PFB input stream, phase is the write address
//   m_axis_*           : reordered output stream, phase is the bin index
//   frame_err          : sticky, a frame closed with tlast/length disagreeing
module pfb_circ_shift_2048mmax
    import pfb_circ_shift_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 11,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  sync_reset_n,
    input  logic [ADDR_WIDTH:0]   num_phases,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [ADDR_WIDTH-1:0] s_axis_phase,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [ADDR_WIDTH-1:0] m_axis_phase,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  frame_err
);

    localparam int FIFO_DEPTH = 2**FIFO_ADDR_WIDTH;
    // Two reads may be in flight behind the FIFO, so stop issuing early.
    localparam logic [FIFO_ADDR_WIDTH:0] FIFO_AF_LVL = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH - 3);

    typedef struct packed {
        logic                  tlast;
        logic [ADDR_WIDTH-1:0] phase;
        logic [DATA_WIDTH-1:0] data;
    } out_ent_t;

    // Setup registers
    logic [ADDR_WIDTH-1:0] mask_q, mask_d, half_q, half_d;
    logic                  rdy_en_q;

    // Bank / frame state
    logic [1:0]            bank_full_q, bank_full_d;
    logic [1:0]            bank_par_q, bank_par_d;
    logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic                  wr_parity_q, wr_parity_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                  frame_err_q, frame_err_d;

    // Read pipeline sideband, aligned with the RAM latency
    rd_pipe_t [2:1]        pipe_q, pipe_d;

    // Output FIFO
    out_ent_t                 fifo_mem [FIFO_DEPTH];
    out_ent_t                 fifo_in, fifo_head;
    logic [FIFO_ADDR_WIDTH-1:0] fifo_wr_ptr_q, fifo_wr_ptr_d, fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]   fifo_cnt_q, fifo_cnt_d;
    logic                     fifo_push, fifo_pop;

    logic                  wr_acc, wr_at_end, wr_close;
    logic                  rd_active, rd_at_end, rd_release;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    always_comb begin
        mask_d = ADDR_WIDTH'(num_phases - (ADDR_WIDTH+1)'(1));
        half_d = ADDR_WIDTH'(num_phases >> 1);

        // Write side
        s_axis_tready = rdy_en_q & ~bank_full_q[wr_bank_q];
        wr_acc        = s_axis_tvalid & s_axis_tready;
        wr_at_end     = (wr_cnt_q == mask_q);
        wr_close      = wr_acc & (s_axis_tlast | wr_at_end);

        // Read side
        rd_active  = bank_full_q[rd_bank_q] && (fifo_cnt_q <= FIFO_AF_LVL);
        rd_at_end  = (rd_cnt_q == mask_q);
        rd_release = rd_active & rd_at_end;
        rd_addr    = calc_rd_addr(rd_cnt_q, bank_par_q[rd_bank_q], half_q, mask_q);

        // Write close and read release always target different banks:
        // the writer only owns an empty bank, the reader only a full one.
        bank_full_d = bank_full_q;
        bank_par_d  = bank_par_q;
        if (wr_close) begin
            bank_full_d[wr_bank_q] = 1'b1;
            bank_par_d[wr_bank_q]  = wr_parity_q;
        end
        if (rd_release) bank_full_d[rd_bank_q] = 1'b0;

        wr_bank_d   = wr_bank_q ^ wr_close;
        wr_parity_d = wr_parity_q ^ wr_close;
        rd_bank_d   = rd_bank_q ^ rd_release;

        wr_cnt_d = wr_cnt_q;
        if (wr_close)    wr_cnt_d = '0;
        else if (wr_acc) wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);

        rd_cnt_d = rd_cnt_q;
        if (rd_active) rd_cnt_d = rd_at_end ? '0 : rd_cnt_q + ADDR_WIDTH'(1);

        frame_err_d = frame_err_q | (wr_acc & (s_axis_tlast != wr_at_end));

        pipe_d[1] = '{valid: rd_active, tlast: rd_at_end, phase: rd_cnt_q};
        pipe_d[2] = pipe_q[1];

        // Output FIFO, first-word fall-through
        fifo_push = pipe_q[2].valid;
        fifo_in   = '{tlast: pipe_q[2].tlast, phase: pipe_q[2].phase, data: ram_rd_data};
        fifo_head = fifo_mem[fifo_rd_ptr_q];

        m_axis_tvalid = (fifo_cnt_q != '0);
        m_axis_tdata  = m_axis_tvalid ? fifo_head.data  : '0;
        m_axis_phase  = m_axis_tvalid ? fifo_head.phase : '0;
        m_axis_tlast  = m_axis_tvalid & fifo_head.tlast;
        fifo_pop      = m_axis_tvalid & m_axis_tready;

        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        if (fifo_push) fifo_wr_ptr_d = fifo_wr_ptr_q + FIFO_ADDR_WIDTH'(1);
        if (fifo_pop)  fifo_rd_ptr_d = fifo_rd_ptr_q + FIFO_ADDR_WIDTH'(1);
        if (fifo_push && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + (FIFO_ADDR_WIDTH+1)'(1);
        else if (!fifo_push && fifo_pop) fifo_cnt_d = fifo_cnt_q - (FIFO_ADDR_WIDTH+1)'(1);

        frame_err = frame_err_q;
    end

    always_ff @(posedge clk) begin
        mask_q <= mask_d;
        half_q <= half_d;
        if (!sync_reset_n) begin
            rdy_en_q      <= 1'b0;
            bank_full_q   <= '0;
            bank_par_q    <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_parity_q   <= 1'b0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            frame_err_q   <= 1'b0;
            pipe_q        <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            rdy_en_q      <= 1'b1;
            bank_full_q   <= bank_full_d;
            bank_par_q    <= bank_par_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_parity_q   <= wr_parity_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            frame_err_q   <= frame_err_d;
            pipe_q        <= pipe_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[fifo_wr_ptr_q] <= fifo_in;
    end

    // Bank select is the RAM address MSB.
    pfb_circ_shift_2048mmax_ram #(
        .RAM_AW (ADDR_WIDTH + 1),
        .RAM_DW (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr ({wr_bank_q, s_axis_phase & mask_q}),
        .wr_data (s_axis_tdata),
        .rd_addr ({rd_bank_q, rd_addr}),
        .rd_data (ram_rd_data)
    );

endmodule
